// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings, divisor helpers.
// Reused by uart_rx and the planned uart_tx.
package uart_rx_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE  = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // state        | meaning
  // ST_IDLE      | line idle, waiting for a 1->0 start edge
  // ST_START     | start bit, verified at its centre
  // ST_DATA      | eight data bits, LSB first, sampled at bit centre
  // ST_PARITY    | even-parity bit (parity build only)
  // ST_STOP      | stop bit, decides rx_valid or rx_error
  // ST_WAIT_HIGH | framing error, waiting for line to return high
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and ticks on the terminal count.
// Synchronous clear holds the count at zero so ticks align to the start edge.
module uart_rx_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  always_comb begin
    at_max = (cnt_q == CNT_MAX);
    tick   = at_max && !clr;
    cnt_d  = cnt_q + CNT_W'(1);
    if (clr || at_max) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// Emits one-cycle rx_valid / rx_error strobes per received frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy
);

  // state        | meaning
  // ST_IDLE      | waiting for start edge, baud counter held clear
  // ST_START     | confirm start bit low at its centre, else false start
  // ST_DATA      | shift in 8 bits LSB first at each bit centre
  // ST_PARITY    | capture even-parity bit (UART_RX_PARITY_EN only)
  // ST_STOP      | stop-bit centre: good frame or error, leaves early for back-to-back
  // ST_WAIT_HIGH | after framing error, hold until line idles high

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned PH_W = cnt_width(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_MID = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_END = PH_W'(OVERSAMPLE - 1);

  rx_state_e       state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rxs_q, rxs_d;
  logic            rxs_prev_q, rxs_prev_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
`ifdef UART_RX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic tick;
  logic baud_clr;
  logic fall;
  logic tick_mid;
  logic tick_end;
  logic parity_ok;
  logic frame_ok;

  assign baud_clr = (state_q == ST_IDLE);

  uart_rx_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (baud_clr),
    .tick    (tick)
  );

  always_comb begin
    sync1_d    = rxd;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
    fall       = rxs_prev_q && !rxs_q;
    tick_mid   = tick && (phase_q == PH_MID);
    tick_end   = tick && (phase_q == PH_END);
`ifdef UART_RX_PARITY_EN
    parity_ok  = !(^{shift_q, parity_q});
`else
    parity_ok  = 1'b1;
`endif
    frame_ok   = rxs_q && parity_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      phase_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
`ifdef UART_RX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (tick_mid) state_d = rxs_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick_end && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_end) state_d = ST_STOP;
      end
`endif
      // Leaving at stop centre lets a start edge in the second half be accepted.
      ST_STOP: begin
        if (tick_end) state_d = rxs_q ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif

    if ((state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH)) begin
      phase_d = '0;
      bit_d   = '0;
    end else if (tick) begin
      if (((state_q == ST_START) && tick_mid) || tick_end) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end

    if ((state_q == ST_DATA) && tick_end) begin
      shift_d = {rxs_q, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end

`ifdef UART_RX_PARITY_EN
    if ((state_q == ST_PARITY) && tick_end) begin
      parity_d = rxs_q;
    end
`endif

    if ((state_q == ST_STOP) && tick_end) begin
      valid_d = frame_ok;
      error_d = !frame_ok;
      if (frame_ok) data_d = shift_q;
    end
  end

  always_comb begin
    rx_data  = data_q;
    rx_valid = valid_q;
    rx_error = error_q;
    rx_busy  = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a strobe scoreboard; parity case under UART_RX_PARITY_EN.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME = 176;
`else
  localparam int FRAME = 160;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_busy;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   exp_valid = 0;
  int   exp_err = 0;
  int   last_strobe_cyc = 0;
  int   prev_strobe_cyc = 0;
  logic busy_seen = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];

  uart_rx #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic err, input logic [7:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    sb.push_back(e);
    if (err) exp_err++;
    else exp_valid++;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_data = rx_data;
    end else begin
      if (rx_data !== prev_data) check("data_only_with_valid", {31'd0, rx_valid}, 32'd1);
      prev_data = rx_data;
      if (rx_busy) busy_seen = 1'b1;
      if (rx_valid || rx_error) begin
        prev_strobe_cyc = last_strobe_cyc;
        last_strobe_cyc = cyc;
        if (rx_valid) n_valid++;
        if (rx_error) n_err++;
        check("strobe_exclusive", {31'd0, rx_valid & rx_error}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, rx_valid, rx_error}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_err", {31'd0, rx_error}, {31'd0, e.err});
          check("strobe_valid", {31'd0, rx_valid}, {31'd0, ~e.err});
          check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    @(negedge clk) rxd = v;
    repeat (15) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk) rxd = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [7:0] bb;
    bb = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(bb[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bz) rxd = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k;

    repeat (3) @(negedge clk);
    #1;
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_error", {31'd0, rx_error}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    idle(5);

    // 1: single good frame
    b = 8'h41;
    push_exp(1'b0, b);
    send_frame(b, ^b, 1'b1);
    idle(20);
    wait_drain(100);
    last_good = b;
    check("t1_valid_count", n_valid, 32'd1);
    check("t1_error_count", n_err, 32'd0);
    check("t1_busy_after", {31'd0, rx_busy}, 32'd0);
    check("t1_rx_data", {24'd0, rx_data}, 32'h41);

    // 2: false start, 4 clocks low
    busy_seen = 1'b0;
    @(negedge clk) rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    k = 0;
    while (k < 10 && rx_busy) begin
      @(negedge clk);
      k++;
    end
    check("t2_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("t2_busy_drop", {31'd0, rx_busy}, 32'd0);
    idle(20);
    check("t2_no_strobe", n_valid + n_err, 32'd1);
    check("t2_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    // 3: bad stop, line held low, then a good frame
    b = 8'h55;
    push_exp(1'b1, last_good);
    send_frame(b, ^b, 1'b0);
    @(negedge clk) rxd = 1'b0;
    repeat (47) @(negedge clk);
    idle(20);
    check("t3_one_error", n_err, 32'd1);
    check("t3_data_held", {24'd0, rx_data}, {24'd0, last_good});
    b = 8'h5A;
    push_exp(1'b0, b);
    send_frame(b, ^b, 1'b1);
    idle(20);
    wait_drain(100);
    last_good = b;
    check("t3_error_total", n_err, 32'd1);

    // 4: back-to-back frames
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'hFF);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(20);
    wait_drain(100);
    last_good = 8'hFF;
    check("t4_spacing", last_strobe_cyc - prev_strobe_cyc, FRAME);
    check("t4_rx_data", {24'd0, rx_data}, 32'hFF);

    // 5: reset during data bit 3, then recover
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    @(negedge clk) rxd = b[3];
    repeat (7) @(negedge clk);
    check("t5_busy_before_reset", {31'd0, rx_busy}, 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("t5_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_reset_rx_error", {31'd0, rx_error}, 32'd0);
    check("t5_reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk) rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    push_exp(1'b0, b);
    send_frame(b, ^b, 1'b1);
    idle(20);
    wait_drain(100);
    last_good = b;

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch, then correct parity
    b = 8'h07;
    push_exp(1'b1, last_good);
    send_frame(b, 1'b0, 1'b1);
    idle(20);
    wait_drain(100);
    check("t6_data_held", {24'd0, rx_data}, {24'd0, last_good});
    check("t6_busy_idle", {31'd0, rx_busy}, 32'd0);
    push_exp(1'b0, b);
    send_frame(b, 1'b1, 1'b1);
    idle(20);
    wait_drain(100);
    last_good = b;
    check("t6_rx_data", {24'd0, rx_data}, 32'h07);
`endif

    check("total_valid", n_valid, exp_valid);
    check("total_error", n_err, exp_err);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
